seg_scan_driver: RTL
====================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL provide parameter BLINK_HALF_MS, default 500, half-period of the expiry blink in clk_1KHz cycles.
REQ-002 SHALL provide parameter SEG_ACTIVE_LOW, default 1; 1 means seg_out and digit_sel are active-low.
REQ-003 clk_1KHz  input  1  system clock; all logic is on its rising edge.
REQ-004 nreset  input  1  reset, asynchronous, active-low.
REQ-005 data_in  input  16  count value from the upstream countdown counter.
REQ-006 dec_mode  input  1  1 = display decimal, 0 = display hex.
REQ-007 blank_lz  input  1  1 = blank leading zero digits.
REQ-008 blink_en  input  1  1 = blink the display when the shown value is 0.
REQ-009 seg_out  output  8  segments; bit7 = dp, bit6 = g, ..., bit0 = a; dp is always off.
REQ-010 digit_sel  output  4  one-hot digit enable; bit0 = least-significant digit.

Function
REQ-011 Conversion FSM SHALL have states IDLE, LOAD, SHIFT, DONE.
- IDLE->LOAD when any of: data_in differs from the last converted value; dec_mode differs from its last converted value; the post-reset force flag is set.
REQ-012 LOAD SHALL snapshot data_in and dec_mode and clear the BCD accumulator.
- Decimal mode: LOAD->SHIFT.
- Hex mode: LOAD->DONE.
REQ-013 SHIFT SHALL run one double-dabble step per cycle (add 3 to each BCD nibble >= 5, then shift) for exactly 16 cycles, then go to DONE.
- Decimal conversion latency: LOAD + 16 SHIFT + DONE = 18 cycles.
REQ-014 DONE SHALL update all four display digit registers atomically, then go to IDLE.
- Hex mode: digits = snapshot nibbles.
- Decimal mode: digits = BCD result.
REQ-015 Decimal snapshot > 9999 SHALL display four dashes (segment g only) on every digit.
REQ-016 data_in changes during LOAD/SHIFT SHALL be ignored until DONE; the IDLE comparison then starts a new conversion.
REQ-017 Scan counter: 2 bits, advances every cycle, wraps 3->0, giving 250 Hz per-digit refresh.
REQ-018 seg_out/digit_sel SHALL be registered, lagging the scan counter by 1 cycle; exactly one digit is enabled when not blanked.
REQ-019 With blank_lz=1, digits above the most-significant nonzero digit SHALL show no segments; digit0 is always shown; dashes are never blanked.
REQ-020 Blink is active when blink_en=1 and the displayed value is 0.
- A counter 0..BLINK_HALF_MS-1 toggles phase on wrap.
- During the OFF phase, all digit_sel bits SHALL be inactive.
- When the blink condition goes false, the counter clears and the phase resets to ON.
REQ-021 Hex digit codes SHALL be the standard 0-F seven-segment glyphs (b, d lowercase).

Reset
REQ-022 nreset low SHALL immediately set:
- FSM = IDLE, force flag = 1;
- display digits = 0, scan counter = 0;
- blink counter = 0, phase = ON;
- seg_out = all segments off, digit_sel = all inactive.
REQ-023 Reset asserted mid-conversion SHALL abort it; a fresh conversion starts on the first cycle after release.

Structure
REQ-024 Package seg_pkg SHALL hold:
- FSM state encoding;
- the 7-segment glyph constants 0-F;
- BLANK and DASH codes;
- digit index constants.
REQ-025 Glyph decoding SHALL be a sub-module seg7_decode: 4-bit digit + blank + dash in, 7 segments out, combinational.

Verification
REQ-026 Reset release, dec_mode=1, data_in=1234 -> after 18 cycles, digit_sel cycles 1110,1101,1011,0111 with glyphs 4,3,2,1.
REQ-027 dec_mode=0, blank_lz=1, data_in=16'h00AF -> digits 3,2 show seg_out=8'hFF; digits 1,0 show A, F.
REQ-028 dec_mode=1, data_in=10000 -> every digit seg_out=8'b1011_1111.
REQ-029 data_in=0, blink_en=1 -> 500 cycles scanning "0" (blank_lz=1, digit0 only), then 500 cycles digit_sel=4'b1111, repeating.
REQ-030 data_in 1234 changed to 42 at SHIFT cycle 5 -> 1234 displayed at DONE; 42 displayed 18 cycles after the following IDLE.
REQ-031 nreset pulsed mid-SHIFT -> outputs go inactive at once; value redisplayed 18 cycles after release.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver: conversion FSM
// states, glyph codes and the double-dabble nibble adjust.
package seg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } conv_state_t;

   // Segment codes, bit6 = g ... bit0 = a, 1 = segment lit
   localparam logic [6:0] GLYPH_0 = 7'h3F;
   localparam logic [6:0] GLYPH_1 = 7'h06;
   localparam logic [6:0] GLYPH_2 = 7'h5B;
   localparam logic [6:0] GLYPH_3 = 7'h4F;
   localparam logic [6:0] GLYPH_4 = 7'h66;
   localparam logic [6:0] GLYPH_5 = 7'h6D;
   localparam logic [6:0] GLYPH_6 = 7'h7D;
   localparam logic [6:0] GLYPH_7 = 7'h07;
   localparam logic [6:0] GLYPH_8 = 7'h7F;
   localparam logic [6:0] GLYPH_9 = 7'h6F;
   localparam logic [6:0] GLYPH_A = 7'h77;
   localparam logic [6:0] GLYPH_B = 7'h7C;
   localparam logic [6:0] GLYPH_C = 7'h39;
   localparam logic [6:0] GLYPH_D = 7'h5E;
   localparam logic [6:0] GLYPH_E = 7'h79;
   localparam logic [6:0] GLYPH_F = 7'h71;
   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_DASH  = 7'h40;

   localparam logic [1:0] DIGIT_0 = 2'd0;
   localparam logic [1:0] DIGIT_1 = 2'd1;
   localparam logic [1:0] DIGIT_2 = 2'd2;
   localparam logic [1:0] DIGIT_3 = 2'd3;

   localparam logic [3:0]  SHIFT_LAST = 4'd15;
   localparam logic [15:0] DEC_MAX    = 16'd9999;

   // Add 3 to every BCD nibble that is 5 or more, ahead of the shift
   function automatic logic [15:0] dd_adjust(input logic [15:0] bcd);
      logic [15:0] adj;
      adj = bcd;
      for (int i = 0; i < 4; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) begin
            adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
         end else begin
            adj[i*4 +: 4] = bcd[i*4 +: 4];
         end
      end
      return adj;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational glyph decoder: one hex digit to seven active-high segments,
// with dash taking priority over blank.
module seg7_decode
   import seg_pkg::*;
(
   input  logic [3:0] i_digit,
   input  logic       i_blank,
   input  logic       i_dash,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      if (i_dash) begin
         o_seg = SEG_DASH;
      end else if (i_blank) begin
         o_seg = SEG_BLANK;
      end else begin
         case (i_digit)
            4'h0:    o_seg = GLYPH_0;
            4'h1:    o_seg = GLYPH_1;
            4'h2:    o_seg = GLYPH_2;
            4'h3:    o_seg = GLYPH_3;
            4'h4:    o_seg = GLYPH_4;
            4'h5:    o_seg = GLYPH_5;
            4'h6:    o_seg = GLYPH_6;
            4'h7:    o_seg = GLYPH_7;
            4'h8:    o_seg = GLYPH_8;
            4'h9:    o_seg = GLYPH_9;
            4'hA:    o_seg = GLYPH_A;
            4'hB:    o_seg = GLYPH_B;
            4'hC:    o_seg = GLYPH_C;
            4'hD:    o_seg = GLYPH_D;
            4'hE:    o_seg = GLYPH_E;
            4'hF:    o_seg = GLYPH_F;
            default: o_seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment driver: serial hex/decimal conversion of the
// count value, leading-zero blanking, overflow dashes and blink on zero.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int BLINK_HALF_MS  = 500,
   parameter bit SEG_ACTIVE_LOW = 1'b1
)
(
   input  logic        clk_1KHz,
   input  logic        nreset,
   input  logic [15:0] data_in,
   input  logic        dec_mode,
   input  logic        blank_lz,
   input  logic        blink_en,
   output logic [7:0]  seg_out,
   output logic [3:0]  digit_sel
);

   localparam int            BW         = $clog2(BLINK_HALF_MS + 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_MS - 1);
   localparam logic [BW-1:0] BLINK_ONE  = BW'(1);
   localparam logic [7:0]    SEG_INV    = {8{SEG_ACTIVE_LOW}};
   localparam logic [3:0]    SEL_INV    = {4{SEG_ACTIVE_LOW}};

   conv_state_t   r_state;
   conv_state_t   w_next_state;
   logic          r_force;
   logic [15:0]   r_snap_data;
   logic          r_snap_dec;
   logic [15:0]   r_bin;
   logic [15:0]   r_bcd;
   logic [15:0]   w_bcd_adj;
   logic [3:0]    r_shift_cnt;
   logic [15:0]   r_digits;
   logic          r_dash;
   logic [1:0]    r_scan;
   logic [BW-1:0] r_blink_cnt;
   logic          r_blink_off;
   logic          w_start;
   logic [3:0]    w_blank;
   logic [3:0]    w_cur_digit;
   logic          w_cur_blank;
   logic [6:0]    w_seg;
   logic          w_blink_cond;

   // Snapshot doubles as "last converted value" for change detection
   assign w_start      = (data_in != r_snap_data) || (dec_mode != r_snap_dec) || r_force;
   assign w_bcd_adj    = dd_adjust(r_bcd);
   assign w_blink_cond = blink_en && !r_dash && (r_digits == 16'h0000);

   always_ff @(posedge clk_1KHz or negedge nreset) begin
      if (!nreset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_start) w_next_state = ST_LOAD;
            else         w_next_state = ST_IDLE;
         end
         ST_LOAD: begin
            if (dec_mode) w_next_state = ST_SHIFT;
            else          w_next_state = ST_DONE;
         end
         ST_SHIFT: begin
            if (r_shift_cnt == SHIFT_LAST) w_next_state = ST_DONE;
            else                           w_next_state = ST_SHIFT;
         end
         ST_DONE: w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_1KHz or negedge nreset) begin
      if (!nreset) begin
         r_force     <= 1'b1;
         r_snap_data <= 16'h0000;
         r_snap_dec  <= 1'b0;
         r_bin       <= 16'h0000;
         r_bcd       <= 16'h0000;
         r_shift_cnt <= 4'd0;
         r_digits    <= 16'h0000;
         r_dash      <= 1'b0;
      end else begin
         case (r_state)
            ST_LOAD: begin
               r_force     <= 1'b0;
               r_snap_data <= data_in;
               r_snap_dec  <= dec_mode;
               r_bin       <= data_in;
               r_bcd       <= 16'h0000;
               r_shift_cnt <= 4'd0;
            end
            ST_SHIFT: begin
               r_bcd       <= {w_bcd_adj[14:0], r_bin[15]};
               r_bin       <= {r_bin[14:0], 1'b0};
               r_shift_cnt <= r_shift_cnt + 4'd1;
            end
            ST_DONE: begin
               if (r_snap_dec) begin
                  r_digits <= r_bcd;
                  r_dash   <= (r_snap_data > DEC_MAX);
               end else begin
                  r_digits <= r_snap_data;
                  r_dash   <= 1'b0;
               end
            end
            default: begin
               r_force <= r_force;
            end
         endcase
      end
   end

   always_comb begin
      w_blank[3] = blank_lz && (r_digits[15:12] == 4'h0);
      w_blank[2] = w_blank[3] && (r_digits[11:8] == 4'h0);
      w_blank[1] = w_blank[2] && (r_digits[7:4] == 4'h0);
      w_blank[0] = 1'b0;
   end

   always_comb begin
      w_cur_digit = r_digits[3:0];
      w_cur_blank = 1'b0;
      case (r_scan)
         DIGIT_0: begin w_cur_digit = r_digits[3:0];   w_cur_blank = w_blank[0]; end
         DIGIT_1: begin w_cur_digit = r_digits[7:4];   w_cur_blank = w_blank[1]; end
         DIGIT_2: begin w_cur_digit = r_digits[11:8];  w_cur_blank = w_blank[2]; end
         DIGIT_3: begin w_cur_digit = r_digits[15:12]; w_cur_blank = w_blank[3]; end
         default: begin w_cur_digit = r_digits[3:0];   w_cur_blank = 1'b0;       end
      endcase
   end

   seg7_decode u_decode (
      .i_digit (w_cur_digit),
      .i_blank (w_cur_blank),
      .i_dash  (r_dash),
      .o_seg   (w_seg)
   );

   always_ff @(posedge clk_1KHz or negedge nreset) begin
      if (!nreset) begin
         r_scan <= 2'd0;
      end else begin
         r_scan <= r_scan + 2'd1;
      end
   end

   // Blink phase only runs while the zero-blink condition holds
   always_ff @(posedge clk_1KHz or negedge nreset) begin
      if (!nreset) begin
         r_blink_cnt <= '0;
         r_blink_off <= 1'b0;
      end else if (w_blink_cond) begin
         if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink_off <= ~r_blink_off;
         end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_ONE;
         end
      end else begin
         r_blink_cnt <= '0;
         r_blink_off <= 1'b0;
      end
   end

   always_ff @(posedge clk_1KHz or negedge nreset) begin
      if (!nreset) begin
         seg_out   <= SEG_INV;
         digit_sel <= SEL_INV;
      end else if (r_blink_off) begin
         seg_out   <= SEG_INV;
         digit_sel <= SEL_INV;
      end else begin
         seg_out   <= {1'b0, w_seg} ^ SEG_INV;
         digit_sel <= (4'b0001 << r_scan) ^ SEL_INV;
      end
   end

endmodule
